// File: rtl/calc2_port_issuer_if.sv
// Signal bundle between an upstream client, calc2_port_issuer and one calc2_top request/response port.
interface calc2_port_issuer_if;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  in_cmd;
  logic [31:0] in_op1;
  logic [31:0] in_op2;
  logic [3:0]  req_cmd_in;
  logic [31:0] req_data_in;
  logic [1:0]  req_tag_in;
  logic [1:0]  out_resp;
  logic [31:0] out_data;
  logic [1:0]  out_tag;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [1:0]  rsp_resp;
  logic [31:0] rsp_data;
  logic [1:0]  rsp_tag;
  logic        busy;

  modport slave (
    input  in_valid, in_cmd, in_op1, in_op2, out_resp, out_data, out_tag, rsp_ready,
    output in_ready, req_cmd_in, req_data_in, req_tag_in,
           rsp_valid, rsp_resp, rsp_data, rsp_tag, busy
  );

  modport master (
    output in_valid, in_cmd, in_op1, in_op2, out_resp, out_data, out_tag, rsp_ready,
    input  in_ready, req_cmd_in, req_data_in, req_tag_in,
           rsp_valid, rsp_resp, rsp_data, rsp_tag, busy
  );
endinterface

// File: rtl/calc2_port_issuer.sv
// Command FIFO, 2-bit tag pool and two-cycle request sequencer for one calc2_top port,
// with per-tag timeout and lowest-tag-first result retirement.
module calc2_port_issuer #(
  parameter int FIFO_DEPTH = 4,
  parameter int TIMEOUT    = 64
) (
  input  logic               c_clk,
  input  logic               reset,
  calc2_port_issuer_if.slave bus
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int TMR_W = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {ST_IDLE, ST_CMD, ST_DATA} state_e;

  typedef struct packed {
    logic [3:0]  cmd;
    logic [31:0] op1;
    logic [31:0] op2;
  } entry_t;

  function automatic logic [1:0] lowest_idx(input logic [3:0] v);
    lowest_idx = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (v[i]) lowest_idx = 2'(i);
    end
  endfunction

  state_e           state_q, state_d;
  entry_t           fifo_q [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic [31:0]      op2_q;

  logic [3:0]       tag_busy_q, tag_busy_d;
  logic [3:0]       pend_q, pend_d;
  logic [1:0]       slot_resp_q [4];
  logic [1:0]       slot_resp_d [4];
  logic [31:0]      slot_data_q [4];
  logic [31:0]      slot_data_d [4];
  logic [TMR_W-1:0] timer_q [4];
  logic [TMR_W-1:0] timer_d [4];

  logic             rsp_valid_q;
  logic [1:0]       rsp_resp_q, rsp_tag_q;
  logic [31:0]      rsp_data_q;

  logic             push, pop, issue_ok, cap, retire;
  logic [1:0]       alloc_tag, next_tag;
  logic [3:0]       avail;

  assign bus.in_ready = (count_q != CNT_W'(FIFO_DEPTH));
  assign push         = bus.in_valid & bus.in_ready;
  assign pop          = (state_q == ST_CMD);
  assign issue_ok     = (count_q != '0) & ~(&tag_busy_q);
  assign alloc_tag    = lowest_idx(~tag_busy_q);
  assign cap          = (bus.out_resp != 2'd0) & tag_busy_q[bus.out_tag];
  assign retire       = rsp_valid_q & bus.rsp_ready;

  always_ff @(posedge c_clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge c_clk) begin
    if (push) fifo_q[wr_ptr_q] <= '{cmd: bus.in_cmd, op1: bus.in_op1, op2: bus.in_op2};
    if (pop)  op2_q <= fifo_q[rd_ptr_q].op2;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (issue_ok) state_d = ST_CMD;
      ST_CMD:  state_d = ST_DATA;
      ST_DATA: state_d = issue_ok ? ST_CMD : ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    bus.req_cmd_in  = '0;
    bus.req_data_in = '0;
    bus.req_tag_in  = '0;
    case (state_q)
      ST_CMD: begin
        bus.req_cmd_in  = fifo_q[rd_ptr_q].cmd;
        bus.req_data_in = fifo_q[rd_ptr_q].op1;
        bus.req_tag_in  = alloc_tag;
      end
      ST_DATA: bus.req_data_in = op2_q;
      default: ;
    endcase
  end

  always_ff @(posedge c_clk) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Precedence within a tag: timeout < captured response < retire.
  always_comb begin
    tag_busy_d  = tag_busy_q;
    pend_d      = pend_q;
    slot_resp_d = slot_resp_q;
    slot_data_d = slot_data_q;
    timer_d     = timer_q;
    for (int t = 0; t < 4; t++) begin
      if (tag_busy_q[t] && !pend_q[t]) begin
        timer_d[t] = timer_q[t] - TMR_W'(1);
        if (timer_q[t] == TMR_W'(1)) begin
          pend_d[t]      = 1'b1;
          slot_resp_d[t] = 2'd0;
          slot_data_d[t] = '0;
        end
      end
    end
    if (cap) begin
      pend_d[bus.out_tag]      = 1'b1;
      slot_resp_d[bus.out_tag] = bus.out_resp;
      slot_data_d[bus.out_tag] = bus.out_data;
      timer_d[bus.out_tag]     = '0;
    end
    if (state_q == ST_CMD) begin
      tag_busy_d[alloc_tag] = 1'b1;
      pend_d[alloc_tag]     = 1'b0;
      timer_d[alloc_tag]    = TMR_W'(TIMEOUT);
    end
    if (retire) begin
      tag_busy_d[rsp_tag_q] = 1'b0;
      pend_d[rsp_tag_q]     = 1'b0;
    end
  end

  always_ff @(posedge c_clk) begin
    if (reset) begin
      tag_busy_q <= '0;
      pend_q     <= '0;
      for (int t = 0; t < 4; t++) timer_q[t] <= '0;
    end else begin
      tag_busy_q <= tag_busy_d;
      pend_q     <= pend_d;
      timer_q    <= timer_d;
    end
  end

  always_ff @(posedge c_clk) begin
    slot_resp_q <= slot_resp_d;
    slot_data_q <= slot_data_d;
  end

  // The slot being retired is excluded so the next result can load on the same edge.
  assign avail    = pend_q & ~(retire ? (4'b0001 << rsp_tag_q) : 4'b0000);
  assign next_tag = lowest_idx(avail);

  always_ff @(posedge c_clk) begin
    if (reset) begin
      rsp_valid_q <= 1'b0;
      rsp_resp_q  <= '0;
      rsp_data_q  <= '0;
      rsp_tag_q   <= '0;
    end else if (!rsp_valid_q || retire) begin
      rsp_valid_q <= |avail;
      if (|avail) begin
        rsp_tag_q  <= next_tag;
        rsp_resp_q <= slot_resp_q[next_tag];
        rsp_data_q <= slot_data_q[next_tag];
      end
    end
  end

  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_resp  = rsp_resp_q;
  assign bus.rsp_data  = rsp_data_q;
  assign bus.rsp_tag   = rsp_tag_q;
  assign bus.busy      = (count_q != '0) | (|tag_busy_q) | (state_q != ST_IDLE);
endmodule

// File: tb/tb_calc2_port_issuer.sv
// Directed bench for calc2_port_issuer: issue sequencing, tag pool, timeout, result ordering, reset.
module tb_calc2_port_issuer;
  localparam int TMO = 16;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  calc2_port_issuer_if bus();

  calc2_port_issuer #(.FIFO_DEPTH(4), .TIMEOUT(TMO)) dut (
    .c_clk(clk),
    .reset(rst),
    .bus  (bus)
  );

  int n_chk  = 0;
  int n_pass = 0;
  int cyc    = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_cmd(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
    for (int k = 0; k < 200 && !bus.in_ready; k++) step();
    check("push_ready", 32'(bus.in_ready), 32'd1);
    bus.in_valid = 1'b1;
    bus.in_cmd   = c;
    bus.in_op1   = a;
    bus.in_op2   = b;
    step();
    bus.in_valid = 1'b0;
  endtask

  task automatic respond(input logic [1:0] r, input logic [31:0] d, input logic [1:0] t);
    bus.out_resp = r;
    bus.out_data = d;
    bus.out_tag  = t;
    step();
    bus.out_resp = 2'd0;
  endtask

  task automatic drain();
    for (int k = 0; k < 2000 && bus.busy; k++) step();
    check("drain_busy", 32'(bus.busy), 32'd0);
  endtask

  // Request/retire monitor, sampled on the falling edge.
  int          iss_cyc[$];
  logic [1:0]  iss_tag[$];
  logic [3:0]  iss_cmd[$];
  logic [31:0] iss_op1[$];
  logic [31:0] iss_op2[$];
  logic [3:0]  dat_cmd[$];
  logic [1:0]  ret_tag[$];
  logic [1:0]  ret_resp[$];
  logic [31:0] ret_data[$];
  bit          in_cmd_phase = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (in_cmd_phase) begin
      iss_op2.push_back(bus.req_data_in);
      dat_cmd.push_back(bus.req_cmd_in);
    end
    in_cmd_phase = (bus.req_cmd_in != 4'd0);
    if (in_cmd_phase) begin
      iss_cyc.push_back(cyc);
      iss_tag.push_back(bus.req_tag_in);
      iss_cmd.push_back(bus.req_cmd_in);
      iss_op1.push_back(bus.req_data_in);
    end
    if (bus.rsp_valid && bus.rsp_ready) begin
      ret_tag.push_back(bus.rsp_tag);
      ret_resp.push_back(bus.rsp_resp);
      ret_data.push_back(bus.rsp_data);
    end
  end

  initial begin
    #100000;
    $display("FAIL sim_timeout: got running expected finished");
    $fatal(1);
  end

  logic [3:0] cmd_tab [9] = '{4'd1, 4'd2, 4'd5, 4'd6, 4'd1, 4'd2, 4'd5, 4'd6, 4'd9};
  int         tag_tab [9] = '{0, 1, 2, 3, 0, 1, 2, 3, 0};

  initial begin
    rst          = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_cmd   = '0;
    bus.in_op1   = '0;
    bus.in_op2   = '0;
    bus.out_resp = '0;
    bus.out_data = '0;
    bus.out_tag  = '0;
    bus.rsp_ready = 1'b0;
    step();
    step();
    check("rst_req_cmd", 32'(bus.req_cmd_in), 32'd0);
    check("rst_req_data", bus.req_data_in, 32'd0);
    check("rst_in_ready", 32'(bus.in_ready), 32'd1);
    check("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    rst = 1'b0;
    step();

    // ADD 5,7 -> two-cycle request on tag 0, result 12 forwarded
    push_cmd(4'd1, 32'd5, 32'd7);
    check("t1_busy", 32'(bus.busy), 32'd1);
    check("t1_idle_cmd", 32'(bus.req_cmd_in), 32'd0);
    step();
    check("t1_cmd", 32'(bus.req_cmd_in), 32'd1);
    check("t1_op1", bus.req_data_in, 32'd5);
    check("t1_tag", 32'(bus.req_tag_in), 32'd0);
    step();
    check("t1_dcmd", 32'(bus.req_cmd_in), 32'd0);
    check("t1_op2", bus.req_data_in, 32'd7);
    step();
    check("t1_back_idle", bus.req_data_in, 32'd0);
    respond(2'd1, 32'd12, 2'd0);
    step();
    check("t1_rsp_valid", 32'(bus.rsp_valid), 32'd1);
    check("t1_rsp_resp", 32'(bus.rsp_resp), 32'd1);
    check("t1_rsp_data", bus.rsp_data, 32'd12);
    check("t1_rsp_tag", 32'(bus.rsp_tag), 32'd0);
    bus.rsp_ready = 1'b1;
    step();
    bus.rsp_ready = 1'b0;
    check("t1_retired", 32'(bus.rsp_valid), 32'd0);
    check("t1_idle_busy", 32'(bus.busy), 32'd0);

    // response on a free tag is dropped; SUB underflow code passed through
    respond(2'd1, 32'd5, 2'd3);
    step();
    step();
    check("t5_free_tag", 32'(bus.rsp_valid), 32'd0);
    check("t5_free_busy", 32'(bus.busy), 32'd0);
    push_cmd(4'd2, 32'd0, 32'd1);
    step();
    check("t5_cmd", 32'(bus.req_cmd_in), 32'd2);
    check("t5_op1", bus.req_data_in, 32'd0);
    step();
    check("t5_op2", bus.req_data_in, 32'd1);
    step();
    respond(2'd2, 32'hFFFF_FFFF, 2'd0);
    step();
    check("t5_rsp_resp", 32'(bus.rsp_resp), 32'd2);
    check("t5_rsp_data", bus.rsp_data, 32'hFFFF_FFFF);
    check("t5_rsp_tag", 32'(bus.rsp_tag), 32'd0);
    bus.rsp_ready = 1'b1;
    step();
    bus.rsp_ready = 1'b0;

    // reset during DATA aborts everything; a late response is ignored
    push_cmd(4'd1, 32'd3, 32'd4);
    step();
    step();
    check("t6_in_data", bus.req_data_in, 32'd4);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("t6_req_cmd", 32'(bus.req_cmd_in), 32'd0);
    check("t6_req_data", bus.req_data_in, 32'd0);
    check("t6_req_tag", 32'(bus.req_tag_in), 32'd0);
    check("t6_busy", 32'(bus.busy), 32'd0);
    check("t6_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    respond(2'd1, 32'd7, 2'd0);
    step();
    step();
    check("t6_late_rsp", 32'(bus.rsp_valid), 32'd0);
    check("t6_late_busy", 32'(bus.busy), 32'd0);

    // nine commands, no responses: tag pool saturates, FIFO fills, timeouts retire in order
    iss_cyc.delete(); iss_tag.delete(); iss_cmd.delete(); iss_op1.delete();
    iss_op2.delete(); dat_cmd.delete();
    ret_tag.delete(); ret_resp.delete(); ret_data.delete();
    bus.rsp_ready = 1'b1;
    for (int i = 0; i < 8; i++) push_cmd(cmd_tab[i], 32'(100 + i), 32'(200 + i));
    check("t3_full", 32'(bus.in_ready), 32'd0);
    check("t3_issued_before", 32'(iss_cmd.size()), 32'd4);
    bus.in_valid = 1'b1;
    bus.in_cmd   = cmd_tab[8];
    bus.in_op1   = 32'd108;
    bus.in_op2   = 32'd208;
    for (int k = 0; k < 3; k++) begin
      step();
      check("t3_held_off", 32'(bus.in_ready), 32'd0);
    end
    for (int k = 0; k < 200 && !bus.in_ready; k++) step();
    check("t3_reopen", 32'(bus.in_ready), 32'd1);
    check("t3_pop_was_5th", 32'(iss_cmd.size()), 32'd5);
    step();
    bus.in_valid = 1'b0;
    drain();
    check("t2_issue_count", 32'(iss_tag.size()), 32'd9);
    check("t2_retire_count", 32'(ret_tag.size()), 32'd9);
    for (int i = 0; i < 9 && i < iss_tag.size() && i < iss_op2.size(); i++) begin
      check($sformatf("t2_tag%0d", i), 32'(iss_tag[i]), 32'(tag_tab[i]));
      check($sformatf("t2_cmd%0d", i), 32'(iss_cmd[i]), 32'(cmd_tab[i]));
      check($sformatf("t2_op1_%0d", i), iss_op1[i], 32'(100 + i));
      check($sformatf("t2_op2_%0d", i), iss_op2[i], 32'(200 + i));
      check($sformatf("t2_dcmd%0d", i), 32'(dat_cmd[i]), 32'd0);
    end
    for (int i = 1; i < 4 && i < iss_cyc.size(); i++)
      check($sformatf("t2_gap%0d", i), 32'(iss_cyc[i] - iss_cyc[i-1]), 32'd2);
    if (iss_cyc.size() >= 5) begin
      check("t2_5th_late", 32'((iss_cyc[4] - iss_cyc[0]) >= TMO), 32'd1);
      check("t2_5th_bound", 32'((iss_cyc[4] - iss_cyc[0]) <= TMO + 6), 32'd1);
    end
    for (int i = 0; i < 9 && i < ret_tag.size(); i++) begin
      check($sformatf("t2_ret_tag%0d", i), 32'(ret_tag[i]), 32'(tag_tab[i]));
      check($sformatf("t2_ret_resp%0d", i), 32'(ret_resp[i]), 32'd0);
      check($sformatf("t2_ret_data%0d", i), ret_data[i], 32'd0);
    end
    bus.rsp_ready = 1'b0;

    // tag 1 occupies the output; tags 2 then 0 answer; tag 0 is presented next and held
    push_cmd(4'd1, 32'd1, 32'd1);
    push_cmd(4'd1, 32'd2, 32'd2);
    push_cmd(4'd1, 32'd3, 32'd3);
    for (int k = 0; k < 4; k++) step();
    respond(2'd1, 32'd111, 2'd1);
    respond(2'd1, 32'd222, 2'd2);
    respond(2'd3, 32'h0000_00AA, 2'd0);
    check("t4_first_valid", 32'(bus.rsp_valid), 32'd1);
    check("t4_first_tag", 32'(bus.rsp_tag), 32'd1);
    check("t4_first_data", bus.rsp_data, 32'd111);
    bus.rsp_ready = 1'b1;
    step();
    bus.rsp_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      check("t4_hold_valid", 32'(bus.rsp_valid), 32'd1);
      check("t4_hold_tag", 32'(bus.rsp_tag), 32'd0);
      check("t4_hold_resp", 32'(bus.rsp_resp), 32'd3);
      check("t4_hold_data", bus.rsp_data, 32'h0000_00AA);
      step();
    end
    bus.rsp_ready = 1'b1;
    step();
    check("t4_next_tag", 32'(bus.rsp_tag), 32'd2);
    check("t4_next_data", bus.rsp_data, 32'd222);
    check("t4_next_resp", 32'(bus.rsp_resp), 32'd1);
    step();
    bus.rsp_ready = 1'b0;
    check("t4_empty", 32'(bus.rsp_valid), 32'd0);
    check("t4_busy", 32'(bus.busy), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
